// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - opcode encodings OP_ADD..OP_MULH (5-bit ctrl field)
//   - FSM state type (S_IDLE, S_MUL)
//   - alu_res_t: result + flags of a single-cycle operation
//   - alu_calc(): single-cycle result/flag function. Operands are carried at
//     MAXW bits and masked to the live width w, so one function serves any
//     WIDTH from 4 to MAXW. w is a constant at every call site and folds away.
package alu_pkg;

  localparam int MAXW = 64;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;
  localparam logic [4:0] OP_PASSA = 5'd11;
  localparam logic [4:0] OP_PASSB = 5'd12;
  localparam logic [4:0] OP_MUL   = 5'd13;
  localparam logic [4:0] OP_MULH  = 5'd14;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [MAXW-1:0] y;
    logic            cout;
    logic            ovf;
    logic            zero;
    logic            neg;
    logic            err;
  } alu_res_t;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

  function automatic alu_res_t alu_calc(input logic [MAXW-1:0] a_in,
                                        input logic [MAXW-1:0] b_in,
                                        input logic [4:0]      op,
                                        input int              w);
    logic [MAXW-1:0] mask, a, b, bn, sa, sb;
    logic [MAXW:0]   sum;
    logic [5:0]      msb;
    logic [6:0]      cbit;
    logic [5:0]      sh;
    alu_res_t        r;
    mask = '1;
    if (w < MAXW) mask = ~(mask << w);
    msb  = 6'(w - 1);
    cbit = 7'(w);
    a    = a_in & mask;
    b    = b_in & mask;
    bn   = ~b & mask;
    // sign-extended copies for signed compare / arithmetic shift
    sa   = a[msb] ? (a | ~mask) : a;
    sb   = b[msb] ? (b | ~mask) : b;
    sh   = b[5:0] & msb;
    sum  = '0;
    r    = '0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        r.y    = sum[MAXW-1:0] & mask;
        r.cout = sum[cbit];
        r.ovf  = (a[msb] == b[msb]) && (r.y[msb] != a[msb]);
      end
      OP_SUB: begin
        // a + ~b + 1: carry out of the live width means no borrow
        sum    = {1'b0, a} + {1'b0, bn} + {{MAXW{1'b0}}, 1'b1};
        r.y    = sum[MAXW-1:0] & mask;
        r.cout = sum[cbit];
        r.ovf  = (a[msb] != b[msb]) && (r.y[msb] != a[msb]);
      end
      OP_AND:   r.y = a & b;
      OP_OR:    r.y = a | b;
      OP_XOR:   r.y = a ^ b;
      OP_NOR:   r.y = ~(a | b) & mask;
      OP_SLL:   r.y = (a << sh) & mask;
      OP_SRL:   r.y = a >> sh;
      OP_SRA:   r.y = ($signed(sa) >>> sh) & mask;
      OP_SLT:   r.y[0] = $signed(sa) < $signed(sb);
      OP_SLTU:  r.y[0] = a < b;
      OP_PASSA: r.y = a;
      OP_PASSB: r.y = b;
      OP_MUL, OP_MULH: ;  // produced by the sequential multiplier
      default:  r.err = 1'b1;
    endcase
    if (!r.err) begin
      r.zero = (r.y == '0);
      r.neg  = r.y[msb];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation request (valid/ready + operands) and result
// response (valid/ready + result + flags) of alu_pipe.
//   master: the datapath side that issues ops and consumes results
//   slave : the ALU
interface alu_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic             err;

  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, y, cout, ovf, zero, neg, err
  );

  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, y, cout, ovf, zero, neg, err
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-cycle iterative unsigned shift-add multiplier.
//   clk, rst : clock, async active-high reset (shared with parent)
//   start    : load a, b, hi_sel and begin iterating
//   a, b     : unsigned operands
//   hi_sel   : 1 -> return high half of a*b, 0 -> low half
//   done     : high during the last iteration; result is valid that cycle
//   result   : selected half of the product (combinational, with done)
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_sel,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic               hi_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH:0]     acc;

  // Low half starts as the multiplier; each step consumes its LSB, adds the
  // multiplicand into the high half and shifts the whole register right.
  always_comb begin
    acc      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {acc, prod[WIDTH-1:1]};
  end

  assign done   = busy && (count == CW'(WIDTH - 1));
  // Result is taken from the final step's next value so the parent can
  // register it on the same edge the last iteration completes.
  assign result = hi_q ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      hi_q  <= 1'b0;
      count <= '0;
      mcand <= '0;
      prod  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      hi_q  <= hi_sel;
      count <= '0;
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      prod  <= prod_nxt;
      count <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and flags.
//   clk, rst : clock, async active-high reset
//   bus      : alu_pipe_if.slave
//              in_valid/in_ready/a/b/ctrl   - operation request
//              out_valid/out_ready/y/flags  - result response
// Single-cycle ops load the output register on the accept edge. MUL/MULH
// run in alu_mul_seq for WIDTH cycles with the input side closed; the last
// iteration loads the output register. WIDTH: power of two, 4..64.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);
  state_t           state, state_nxt;
  logic             in_rdy;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  alu_res_t         calc;
  logic             unused_calc;

  logic             vld_q;
  logic [WIDTH-1:0] y_q;
  logic             cout_q, ovf_q, zero_q, neg_q, err_q;

  assign calc        = alu_calc(MAXW'(bus.a), MAXW'(bus.b), bus.ctrl, WIDTH);
  // bits above WIDTH are always zero
  assign unused_calc = ^calc.y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    mul_start = 1'b0;
    case (state)
      S_IDLE: begin
        in_rdy = !vld_q || bus.out_ready;
        if (bus.in_valid && in_rdy && is_mul_op(bus.ctrl)) begin
          mul_start = 1'b1;
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (mul_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = bus.in_valid && in_rdy;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (bus.a),
    .b      (bus.b),
    .hi_sel (bus.ctrl == OP_MULH),
    .done   (mul_done),
    .result (mul_res)
  );

  // mul_done and a single-cycle accept are mutually exclusive: the input
  // side is closed for the whole multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      y_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (mul_done) begin
      vld_q  <= 1'b1;
      y_q    <= mul_res;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= (mul_res == '0);
      neg_q  <= mul_res[WIDTH-1];
      err_q  <= 1'b0;
    end else if (accept && !mul_start) begin
      vld_q  <= 1'b1;
      y_q    <= calc.y[WIDTH-1:0];
      cout_q <= calc.cout;
      ovf_q  <= calc.ovf;
      zero_q <= calc.zero;
      neg_q  <= calc.neg;
      err_q  <= calc.err;
    end else if (bus.out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.y         = y_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the combinational `alu`. It accepts one operation per transaction on a valid/ready input port and returns a registered result with status flags on a valid/ready output port. Single-cycle ops take 1 cycle; MUL and MULH use an iterative shift-add multiplier that takes WIDTH cycles. It sits between operand fetch and writeback in the datapath.

## Interface
- `WIDTH`, default 32: operand and result width, ≥4, power of two.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operation offered.
- `in_ready`  output  1  block can accept an operation this cycle.
- `a`, `b`  input  WIDTH  operands.
- `ctrl`  input  5  opcode.
- `out_valid`  output  1  result register holds an unconsumed result.
- `out_ready`  input  1  consumer takes the result.
- `y`  output  WIDTH  result.
- `cout`  output  1  carry out (ADD), or no-borrow (SUB).
- `ovf`  output  1  signed overflow (ADD/SUB only).
- `zero`  output  1  `y == 0`.
- `neg`  output  1  `y[WIDTH-1]`.
- `err`  output  1  illegal opcode.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed), 10 SLTU, 11 PASSA, 12 PASSB, 13 MUL (low WIDTH bits of unsigned a*b), 14 MULH (high WIDTH bits of unsigned a*b).
- Opcodes 15–31 are illegal: y=0, err=1, all other flags 0, latency 1.
- Shift amount is `b[log2(WIDTH)-1:0]`; upper bits of b are ignored.
- SUB is computed as a + ~b + 1, with cout = carry of that sum (1 means no borrow).
- ovf is set on signed overflow for ADD/SUB; it is 0 for all other ops.
- cout is 0 for all ops except ADD and SUB.
- SLT and SLTU produce y = {0…, lt}.
- zero and neg are derived from the registered y for every legal op.
- FSM states:
  - IDLE: accepts operations.
  - MUL: iterating; count runs 0..WIDTH-1.
- Transitions:
  - IDLE→MUL on accept of op 13 or 14.
  - MUL→IDLE on the iteration where count==WIDTH-1; that edge also loads the output register.
- Multiplier: 2·WIDTH-bit product register with a shift-add step of one bit of b per cycle. The op select (low/high half) is latched at accept.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- Accept occurs on an edge where in_valid && in_ready.
- The output register (y, flags, out_valid) holds stable while out_valid && !out_ready.

## Timing
- Reset values:
  - state=IDLE, count=0, out_valid=0, y=0, cout=ovf=zero=neg=err=0.
  - in_ready is 1 after reset.
- Non-MUL op accepted at edge N: out_valid=1 and y valid after edge N.
- MUL/MULH accepted at edge N: out_valid=1 after edge N+WIDTH.
  - in_ready=0 from after edge N through edge N+WIDTH.
- Back-to-back: with out_ready held at 1, a new single-cycle op is accepted every cycle, giving throughput 1/cycle.
- Simultaneous consume and accept on one edge: the output register loads the new result and out_valid stays 1.
- Consume with no accept: out_valid→0 on that edge.
- A multiply completing while the previous result is still unconsumed cannot happen: MUL is entered only with in_ready=1, and out_valid can only be 0 or consumed before then.
- rst asserted mid-multiply clears state immediately (asynchronous). The partial product is discarded and no result is emitted.
- Inputs a, b, ctrl are sampled only at accept; changes at any other time have no effect.

## Structure
- Package `alu_pkg`:
  - opcode localparams (OP_ADD..OP_MULH);
  - state typedef/encoding (S_IDLE, S_MUL);
  - function computing the single-cycle result and flags.
- Sub-module `alu_mul_seq`:
  - ports: start, a, b, hi_sel, done, result;
  - WIDTH-cycle iterative unsigned multiplier;
  - reset shared with the parent.
- Top level `alu_pipe` contains the handshake, FSM, output register and flag generation.

## Test plan
- WIDTH=32, a=16, b=3, sweep ctrl 0..14 with out_ready=1:
  - ADD→19, SUB→13, AND→0, OR→19, XOR→19, NOR→0xFFFFFFEC;
  - SLL→128, SRL→2, SRA→2, SLT→0, SLTU→0, PASSA→16, PASSB→3;
  - MUL→48 with out_valid exactly 32 cycles after accept; MULH→0.
- Flags:
  - ADD 0x7FFFFFFF+1 → y=0x80000000, ovf=1, neg=1, cout=0.
  - SUB 3−16 → y=0xFFFFFFF3, cout=0, neg=1.
  - SUB 5−5 → y=0, zero=1, cout=1.
- MULH 0xFFFFFFFF×0xFFFFFFFF → y=0xFFFFFFFE. A following MUL with the same operands → y=1. in_ready=0 throughout each multiply.
- Backpressure:
  - Hold out_ready=0 after an ADD result: y and flags stay stable and in_ready=0.
  - Raise out_ready together with in_valid on the next op: the new result replaces the old on the same edge.
- Illegal ctrl=31 → y=0, err=1, latency 1. The next legal op clears err.
- Assert rst 10 cycles into a MUL: all outputs go to 0 without waiting for a clock edge. The next ADD 16+3 → 19.
